// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared nibble width and FSM state encodings
// for the nibble-serial add/sub sequencer and its nibble adder.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'b00;
   localparam state_t S_RUN  = 2'b01;
   localparam state_t S_DONE = 2'b10;

endpackage

// File: rtl/nibble_serial_adder_adder.sv
// nibble_adder: combinational 4-bit ripple adder of full-adder cells.
// Ports: a, b, ci in; s sum, co carry out, c3 carry into bit 3 out.
module nibble_adder
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co,
   output logic                c3
);

   logic [NIBBLE_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[NIBBLE_W];
   assign c3 = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds/subtracts two NIBBLES-wide operands one nibble
// per cycle, LSB first. Ports: clk, rst, start/sub/ci/a/b in;
// busy, done, sum, cout, ovf out.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         sub,
   input  logic                         ci,
   input  logic [NIBBLE_W*NIBBLES-1:0]  a,
   input  logic [NIBBLE_W*NIBBLES-1:0]  b,
   output logic                         busy,
   output logic                         done,
   output logic [NIBBLE_W*NIBBLES-1:0]  sum,
   output logic                         cout,
   output logic                         ovf
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = $clog2(NIBBLES);

   state_t                state;
   logic [W-1:0]          a_sh;
   logic [W-1:0]          b_sh;
   logic                  carry_r;
   logic [IW-1:0]         idx;

   logic [NIBBLE_W-1:0]   nib;
   logic                  nco;
   logic                  nc3;

   logic                  is_run;
   logic                  is_done;
   logic                  is_idle;
   logic                  last;

   nibble_adder u_add (
      .a  (a_sh[NIBBLE_W-1:0]),
      .b  (b_sh[NIBBLE_W-1:0]),
      .ci (carry_r),
      .s  (nib),
      .co (nco),
      .c3 (nc3)
   );

   // Illegal encoding 2'b11 behaves as IDLE.
   assign is_run  = (state == S_RUN);
   assign is_done = (state == S_DONE);
   assign is_idle = !is_run && !is_done;
   assign last    = (idx == IW'(NIBBLES - 1));

   assign busy = is_run || is_done;
   assign done = is_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         carry_r <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         unique case (1'b1)
            is_idle: begin
               if (start) begin
                  state   <= S_RUN;
                  a_sh    <= a;
                  b_sh    <= sub ? ~b : b;
                  carry_r <= sub ? 1'b1 : ci;
                  idx     <= '0;
                  sum     <= '0;
                  cout    <= 1'b0;
                  ovf     <= 1'b0;
               end
            end
            is_run: begin
               sum     <= {nib, sum[W-1:NIBBLE_W]};
               a_sh    <= a_sh >> NIBBLE_W;
               b_sh    <= b_sh >> NIBBLE_W;
               carry_r <= nco;
               idx     <= idx + 1'b1;
               if (last) begin
                  cout  <= nco;
                  ovf   <= nc3 ^ nco;
                  state <= S_DONE;
               end
            end
            is_done: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequencer that adds or subtracts two multi-nibble operands by time-multiplexing a single 4-bit ripple-carry nibble adder. It runs one nibble per cycle, least significant first, with a registered carry between nibbles. It sits between a requester using a start/done handshake and the shared 4-bit adder datapath, so wide sums cost cycles instead of area.

## Interface
- NIBBLES, default 4: operand width in nibbles. Legal range is 2..16. Operand width W = 4*NIBBLES.
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- sub  in  1  0 = a+b+ci; 1 = a-b, computed as a + ~b + 1 (ci ignored). Sampled with start.
- ci  in  1  carry-in for add; sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid.
- sum  out  W  result; held until the next accepted start.
- cout  out  1  carry out of the MSB nibble. For sub this is no-borrow: 1 when a >= b unsigned.
- ovf  out  1  two's-complement overflow = carry into MSB bit XOR carry out of MSB bit.

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN on start=1:
  - latch a into a_sh.
  - latch b into b_sh; store ~b when sub=1.
  - carry_r <= (sub ? 1 : ci).
  - idx <= 0.
  - clear sum, cout and ovf to 0.
- Each RUN cycle:
  - nibble adder computes a_sh[3:0] + b_sh[3:0] + carry_r.
  - the nibble result shifts into sum from the top (sum <= {nib, sum[W-1:4]}).
  - a_sh and b_sh shift right by 4.
  - carry_r <= nibble carry-out.
  - idx increments.
- On the RUN cycle with idx = NIBBLES-1, the same edge also:
  - registers cout = nibble carry-out.
  - registers ovf = carry into bit 3 XOR carry-out.
  - moves to DONE.
- DONE to IDLE unconditionally. done=1 only in DONE.
- start outside IDLE is ignored and not queued. sub, ci, a and b are don't-care outside the start cycle.
- All arithmetic is modulo 2^W. No saturation.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, carry_r 0, idx 0.
- rst has priority over every other input.
- Reset in RUN or DONE aborts the operation. No done is issued, and outputs clear on the following edge.
- Latency: start accepted at edge 0, RUN occupies edges 1..NIBBLES, done is high in the cycle after edge NIBBLES. Total is NIBBLES+1 cycles from start to done.
- sum, cout and ovf are stable and valid from the done cycle until the edge that accepts the next start.
- Maximum throughput is one operation per NIBBLES+2 cycles. The earliest next start is the cycle after done, back in IDLE.
- start held high continuously re-triggers at every IDLE cycle.
- The adder is purely combinational inside one cycle. There are no multicycle paths.

## Structure
- The shared package holds:
  - NIBBLE_W = 4.
  - the state type with encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10. 2'b11 is illegal and decodes to IDLE.
- Sub-module: nibble_adder, a combinational 4-bit ripple adder built from full-adder cells.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, c3 (carry into bit 3, used for ovf).
- One nibble_adder instance. The FSM, shift registers and idx counter live in the top module.

## Test plan
All scenarios use NIBBLES=4.
- Add: a=0x1234, b=0x0FCD, ci=0 -> done at cycle 5 after start, sum=0x2201, cout=0, ovf=0. busy is high for exactly 5 cycles.
- Wrap: a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, cout=1, ovf=0. Then a=0xFFFF, b=0x0000, ci=1 -> sum=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007, ci=1 (must be ignored) -> sum=0xFFFE, cout=0. Then sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Handshake: start pulsed again during RUN with a new operand -> ignored, and the first result is unchanged. start held high -> consecutive done pulses exactly 6 cycles apart.
- Reset mid-op: rst=1 at the second RUN cycle -> no done, and the next cycle shows busy=0, sum=0, cout=0, ovf=0. A new start then completes normally.
